// File: rtl/link_parameter_loader_pkg.sv
// ============================================================================
// link_parameter_loader_pkg: shared stage and boundary-condition encodings.
// Rev 1.0
// ============================================================================
`default_nettype none

package link_parameter_loader_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd6;

  localparam logic [1:0] BC_NONE        = 2'd0;
  localparam logic [1:0] BC_BOUNDARY    = 2'd1;
  localparam logic [1:0] BC_NONEXISTENT = 2'd2;
  localparam logic [1:0] BC_FIFO        = 2'd3;

  function automatic int link_bit_width(input int max_weight);
    return $clog2(max_weight + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/link_parameter_loader_if.sv
// ============================================================================
// link_parameter_loader_if: valid/ready parameter word stream into the loader.
// Rev 1.0
// ============================================================================
`default_nettype none

interface link_parameter_loader_if #(
  parameter int LINK_BIT_WIDTH = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LINK_BIT_WIDTH-1:0] in_weight;
  logic [1:0]                in_boundary;

  modport master (output in_valid, in_weight, in_boundary, input in_ready);
  modport slave  (input in_valid, in_weight, in_boundary, output in_ready);
endinterface

`default_nettype wire

// File: rtl/link_param_mem.sv
// ============================================================================
// link_param_mem: register file, synchronous write, asynchronous read.
// Rev 1.0
// ============================================================================
`default_nettype none

module link_param_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  wire logic              clk,
  input  wire logic              wr_en,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [WIDTH-1:0]  wr_data,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output logic      [WIDTH-1:0]  rd_data
);

  // Contents are deliberately unreset; a full fill always precedes replay.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/link_parameter_loader.sv
// ============================================================================
// link_parameter_loader: buffers per-link parameters, replays them reversed
// into the head of the systolic chain during parameter loading.  Rev 1.0
// ============================================================================
`default_nettype none

module link_parameter_loader
  import link_parameter_loader_pkg::*;
#(
  parameter  int NUM_LINKS      = 16,
  parameter  int MAX_WEIGHT     = 2,
  localparam int LINK_BIT_WIDTH = link_bit_width(MAX_WEIGHT)
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic [STAGE_WIDTH-1:0] global_stage,
  input  wire logic                   reload,
  link_parameter_loader_if.slave      in_bus,
  output logic [LINK_BIT_WIDTH-1:0]   weight_out,
  output logic [1:0]                  boundary_condition_out,
  output logic                        params_ready,
  output logic                        load_done,
  output logic                        overrun
);

  localparam int PTR_W  = ptr_width(NUM_LINKS);
  localparam int WORD_W = LINK_BIT_WIDTH + 2;

  localparam logic [PTR_W-1:0]          c_LAST       = PTR_W'(NUM_LINKS - 1);
  localparam logic [LINK_BIT_WIDTH-1:0] c_MAX_WEIGHT = LINK_BIT_WIDTH'(MAX_WEIGHT);

  localparam logic [1:0] c_FILL   = 2'd0;
  localparam logic [1:0] c_READY  = 2'd1;
  localparam logic [1:0] c_STREAM = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_cnt;
  logic             r_overrun;
  logic             r_load_done;

  logic                      w_loading;
  logic                      w_write;
  logic                      w_replay;
  logic [LINK_BIT_WIDTH-1:0] w_weight_clamped;
  logic [WORD_W-1:0]         w_wr_data;
  logic [WORD_W-1:0]         w_rd_data;
  logic [PTR_W-1:0]          w_rd_addr;

  assign w_loading        = (global_stage == STAGE_PARAMETERS_LOADING);
  assign w_write          = (r_state == c_FILL) && in_bus.in_valid && !reload;
  assign w_weight_clamped = (in_bus.in_weight > c_MAX_WEIGHT) ? c_MAX_WEIGHT : in_bus.in_weight;
  assign w_wr_data        = {w_weight_clamped, in_bus.in_boundary};
  // Each link shifts onward every loading cycle, so the far end goes first.
  assign w_rd_addr        = c_LAST - r_rd_cnt;
  assign w_replay         = w_loading && ((r_state == c_READY) || (r_state == c_STREAM));

  link_param_mem #(
    .DEPTH  (NUM_LINKS),
    .WIDTH  (WORD_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_write),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wr_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_FILL;
      r_wr_ptr    <= '0;
      r_rd_cnt    <= '0;
      r_overrun   <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      if (reload) begin
        r_state   <= c_FILL;
        r_wr_ptr  <= '0;
        r_rd_cnt  <= '0;
        r_overrun <= 1'b0;
      end else begin
        case (r_state)
          c_FILL: begin
            if (in_bus.in_valid) begin
              if (r_wr_ptr == c_LAST) begin
                r_state  <= c_READY;
                r_wr_ptr <= '0;
              end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
              end
            end
          end
          c_READY, c_STREAM: begin
            if (w_loading) begin
              if (r_rd_cnt == c_LAST) begin
                r_state     <= c_DONE;
                r_rd_cnt    <= '0;
                r_load_done <= 1'b1;
              end else begin
                r_state  <= c_STREAM;
                r_rd_cnt <= r_rd_cnt + 1'b1;
              end
            end else begin
              // Early exit keeps the buffer; the next period restarts the replay.
              r_state  <= c_READY;
              r_rd_cnt <= '0;
            end
          end
          default: begin
            if (w_loading) begin
              r_overrun <= 1'b1;
            end else begin
              r_state <= c_READY;
            end
          end
        endcase
      end
    end
  end

  assign in_bus.in_ready        = (r_state == c_FILL);
  assign params_ready           = (r_state != c_FILL);
  assign weight_out             = w_replay ? w_rd_data[WORD_W-1:2] : '0;
  assign boundary_condition_out = w_replay ? w_rd_data[1:0] : 2'd0;
  assign load_done              = r_load_done;
  // Visible in the first surplus loading cycle, then held by the sticky flag.
  assign overrun                = r_overrun | ((r_state == c_DONE) && w_loading);

endmodule

`default_nettype wire

// File: doc/link_parameter_loader.md
# link_parameter_loader

Buffers one decoding graph's per-link parameters (weight, boundary condition) from a valid/ready input stream. When the array enters `STAGE_PARAMETERS_LOADING`, it replays them one word per cycle into the head of the systolic parameter chain formed by the `neighbor_link_internal` instances. It sits directly upstream of the first link in that chain and drives that link's `weight_in` and `boundary_condition_in`.

## Interface
Parameters:
- `NUM_LINKS`, 16: links in the chain; word count per parameter set.
- `MAX_WEIGHT`, 2: largest legal link weight. `LINK_BIT_WIDTH = $clog2(MAX_WEIGHT+1)`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `global_stage`  in  `STAGE_WIDTH`  array stage.
- `reload`  in  1  pulse: discard the buffered set and start a new fill.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_weight`  in  `LINK_BIT_WIDTH`  link weight. Word 0 is nearest the loader.
- `in_boundary`  in  2  boundary condition: 0 none, 1 boundary, 2 non-existent, 3 FIFO.
- `weight_out`  out  `LINK_BIT_WIDTH`  to the first link's `weight_in`.
- `boundary_condition_out`  out  2  to the first link's `boundary_condition_in`.
- `params_ready`  out  1  all `NUM_LINKS` words are buffered.
- `load_done`  out  1  one-cycle pulse after a complete replay.
- `overrun`  out  1  sticky: the stage stayed in loading past `NUM_LINKS` cycles.

## Operation
- FSM states are `FILL`, `READY`, `STREAM`, `DONE`. `reset` enters `FILL` with `wr_ptr=0`, `rd_cnt=0`, `overrun=0`.
- `FILL`:
  - `in_ready=1`. On `in_valid`, write `mem[wr_ptr]` and increment `wr_ptr`.
  - A write at `wr_ptr==NUM_LINKS-1` moves to `READY`.
  - `in_weight > MAX_WEIGHT` is clamped to `MAX_WEIGHT` on write.
- `READY`: `params_ready=1`, `in_ready=0`. When `global_stage==STAGE_PARAMETERS_LOADING`, move to `STREAM`.
- Replay order is reversed because each link shifts its parameters onward every loading cycle. During loading cycle k (k=0..NUM_LINKS-1), the outputs present `mem[NUM_LINKS-1-k]`. After NUM_LINKS edges, link i holds word i.
- Outputs are combinational from `mem` and `rd_cnt`. They are valid in `READY` (k=0) and `STREAM` whenever the stage is loading. Otherwise they are 0.
- `STREAM`:
  - `rd_cnt` increments each loading cycle.
  - When the last word (`rd_cnt==NUM_LINKS-1`) is consumed, go to `DONE`, pulse `load_done` and reset `rd_cnt=0`.
  - If the stage leaves loading early, return to `READY` with `rd_cnt=0` and do not pulse `load_done`. The buffer is kept; the next loading period restarts from word NUM_LINKS-1.
- `DONE`:
  - `params_ready=1`. Outputs are 0.
  - If the stage is still loading, set `overrun=1`. It clears only on `reset` or `reload`.
  - When the stage leaves loading, go to `READY`. The same set can be replayed for the next graph.
- `reload` in any state goes to `FILL`, clears `wr_ptr`, `rd_cnt` and `overrun`, and drops `params_ready`. `reload` has priority over `in_valid` in the same cycle; that word is not written.
- The loader never drives `is_error_systolic_in`. The result chain is separate.

## Timing
- Reset values:
  - `in_ready=1`, `params_ready=0`, `load_done=0`, `overrun=0`.
  - `weight_out=0`, `boundary_condition_out=0`.
- Input handshake: transfer when `in_valid && in_ready` at a rising edge. `in_ready` is combinational from the state only.
- Replay latency: word NUM_LINKS-1 is on the outputs in the same cycle that `global_stage` first equals loading, with zero added latency.
- `load_done` is registered. It is high for the one cycle after the edge that consumed word 0.
- Minimum fill time: NUM_LINKS cycles with `in_valid` held high.
- Reset mid-`STREAM` aborts the replay. Links already loaded keep partial values until the next loading period.

## Structure
- `STAGE_WIDTH` and the `STAGE_*` encodings come from the shared parameters include. Boundary-condition encodings 0–3 (`BC_NONE`, `BC_BOUNDARY`, `BC_NONEXISTENT`, `BC_FIFO`) are added there, next to the stage constants.
- One sub-module, `link_param_mem`: a NUM_LINKS × (LINK_BIT_WIDTH+2) register file with a synchronous write port and an asynchronous read port. Register-based, no reset on the contents.

## Test plan
- NUM_LINKS=4: fill weights {1,2,0,2}, BCs {0,1,2,3}, then hold loading 4 cycles. Outputs go (2,3),(0,2),(2,1),(1,0). `load_done` pulses once, and a modelled 4-link chain holds word i at link i.
- `in_weight=3` with MAX_WEIGHT=2. The stored and replayed weight is 2.
- Loading held 2 cycles, then IDLE, then 4 cycles. The first period gives no `load_done`; the second replays from word 3 and completes.
- Loading held 6 cycles. `overrun` rises on cycle 5 and stays high until `reload`. Outputs are 0 on cycles 5–6.
- `reload` and `in_valid` in the same cycle during `READY`. `wr_ptr=0`, the word is not written, and `params_ready` falls next cycle.
- `reset` asserted on the 2nd loading cycle. All outputs return to reset values next cycle and `in_ready=1`.
